uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 16x-oversampled UART transmitter: start bit, NB_DATA bits LSB-first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int NB_DATA = 8,
  parameter int NB_STOP = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_txdone,
  output logic               o_busy
);

  localparam int TW = $clog2((NB_STOP > 16) ? NB_STOP : 16);
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(15);
  localparam logic [TW-1:0] STOP_LAST = TW'(NB_STOP - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;
  logic par_q;
`else
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_DATA  = 4'b0100,
    S_STOP  = 4'b1000
  } state_t;
`endif

  state_t             state_q;
  logic [TW-1:0]      tick_q;
  logic [BW-1:0]      bit_q;
  logic [NB_DATA-1:0] shreg_q;
  logic [NB_DATA-1:0] shreg_d;
  logic               tx_q;
  logic               done_q;
  logic               busy_q;

  assign shreg_d = shreg_q >> 1;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (i_start) begin
            shreg_q <= i_data;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^i_data;
`endif
          end
        end
        S_START: begin
          if (i_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              tx_q    <= shreg_q[0];
              state_q <= S_DATA;
            end else begin
              tick_q <= tick_q + TICK_ONE;
            end
          end
        end
        S_DATA: begin
          if (i_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              shreg_q <= shreg_d;
              if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                tx_q    <= par_q;
                state_q <= S_PARITY;
`else
                tx_q    <= 1'b1;
                state_q <= S_STOP;
`endif
              end else begin
                bit_q <= bit_q + BIT_ONE;
                tx_q  <= shreg_d[0];
              end
            end else begin
              tick_q <= tick_q + TICK_ONE;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (i_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tick_q <= tick_q + TICK_ONE;
            end
          end
        end
`endif
        S_STOP: begin
          if (i_tick) begin
            if (tick_q == STOP_LAST) begin
              tick_q  <= '0;
              tx_q    <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              tick_q <= tick_q + TICK_ONE;
            end
          end
        end
        // Any non-one-hot encoding falls back to a quiet idle line.
        default: begin
          state_q <= S_IDLE;
          tick_q  <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx     = tx_q;
  assign o_txdone = done_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: tick-count line model plus an independent line receiver.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LEN = 16 * 9 + 16 + (PAR ? 16 : 0);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, txdone, busy;

  int n_checks = 0;
  int n_fail = 0;
  int tick_period = 1;

  uart_tx dut (
    .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_start(start), .i_data(data),
    .o_tx(tx), .o_txdone(txdone), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line value k ticks into a frame: 16-tick segments start, d[0..7], [parity], then stop.
  function automatic logic seg_bit(input int k, input logic [7:0] d);
    int s;
    s = k / 16;
    if (s == 0) return 1'b0;
    if (s <= 8) return d[s-1];
    if (PAR && s == 9) return ^d;
    return 1'b1;
  endfunction

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      if (ph >= tick_period) ph = 0;
      tick = (ph == 0);
    end
  end

  // Reference model: a frame is just a count of ticks since acceptance.
  logic       m_active = 1'b0;
  logic       m_done = 1'b0;
  int         m_k = 0;
  logic [7:0] m_data = 8'h00;
  int         n_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (tick) begin
          m_k++;
          if (m_k == LEN) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_data   = data;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("tx", 32'(tx), 32'(m_active ? seg_bit(m_k, m_data) : 1'b1));
      chk("busy", 32'(busy), 32'(m_active));
      chk("txdone", 32'(txdone), 32'(m_done));
      if (txdone) n_done++;
    end
  end

  // Line receiver: finds the falling edge, samples mid-bit by counting ticks.
  logic       tick_seen = 1'b0;
  logic       r_busy = 1'b0;
  int         r_cnt = 0;
  int         r_seg = 0;
  logic [7:0] r_byte = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) tick_seen <= tick;

  always @(negedge clk) begin
    if (!rst_n) begin
      r_busy = 1'b0;
      r_cnt  = 0;
    end else if (!r_busy) begin
      if (tx == 1'b0) begin
        r_busy = 1'b1;
        r_cnt  = 0;
      end
    end else if (tick_seen) begin
      r_cnt++;
      if (r_cnt % 16 == 8) begin
        r_seg = r_cnt / 16;
        if (r_seg == 0) chk("rx_start", 32'(tx), 32'd0);
        else if (r_seg <= 8) r_byte[r_seg-1] = tx;
        else if (PAR && r_seg == 9) chk("rx_parity", 32'(tx), 32'(^r_byte));
        else begin
          chk("rx_stop", 32'(tx), 32'd1);
          rx_q.push_back(r_byte);
          r_busy = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    data = 8'($urandom);
  endtask

  task automatic pulse_start(input logic [7:0] d);
    start = 1'b1;
    data  = d;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    exp_q.push_back(d);
    pulse_start(d);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!txdone && n < limit) begin
      step();
      n++;
    end
    chk("done_seen", 32'(txdone), 32'd1);
  endtask

  initial begin
    int         low_clks;
    logic [7:0] d;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(txdone), 32'd0);
    rst_n = 1'b1;
    repeat (1000) step();

    tick_period = 1;
    send(8'hA5);
    wait_done(LEN * 2);

    tick_period = 4;
    repeat (8) step();
    send(8'h00);
    low_clks = 0;
    while (tx == 1'b0 && low_clks < 2000) begin
      step();
      low_clks++;
    end
    chk("slow_low_len", 32'(low_clks >= 573 && low_clks <= 579), 32'd1);
    wait_done(LEN * 8);

    tick_period = 1;
    repeat (5) step();
    send(8'h55);
    repeat (50) step();
    pulse_start(8'hFF);
    wait_done(LEN * 2);
    send(8'h0F);
    wait_done(LEN * 2);

    for (int i = 0; i < 12; i++) begin
      if (i == 0) d = 8'h07;
      else if (i == 1) d = 8'h03;
      else d = 8'($urandom);
      tick_period = $urandom_range(1, 3);
      send(d);
      if ($urandom_range(0, 2) == 0) begin
        repeat (20) step();
        pulse_start(8'($urandom));
      end
      wait_done(LEN * 4);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 6)) step();
    end

    tick_period = 1;
    repeat (4) step();
    pulse_start(8'h3C);
    repeat (69) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    send(8'hC3);
    wait_done(LEN * 2);

    repeat (3) step();
    pulse_start(8'($urandom));
    repeat (5) step();
    chk("startrst_pre_tx", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("startrst_tx", 32'(tx), 32'd1);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (LEN + 20) step();

    chk("done_count", 32'(n_done), 32'(exp_q.size()));
    chk("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk("rx_byte", 32'(rx_q[i]), 32'(exp_q[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
